uart_tx_sched: RTL
==================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have req_valid  in  4  per-requester frame pending; req_data  in  32  requester i byte on bits [8i+7:8i].
REQ-003 SHALL have req_ready  out  4  one-hot one-cycle accept pulse to requester i.
REQ-004 SHALL have core_tx_req  out  1  start pulse to UART core; core_tx_data  out  8  byte to UART core.
REQ-005 SHALL have core_tx_busy  in  1  UART core transmitter busy; clk16  in  1  16x baud strobe, one clk wide.
REQ-006 SHALL have gap_cfg  in  4  inter-frame idle length, clk16 ticks; err_clr  in  1  clears err_timeout.
REQ-007 SHALL have grant_id  out  2  requester owning current frame; sched_busy  out  1  state != IDLE.
REQ-008 SHALL have err_timeout  out  1  sticky core no-start flag; frame_cnt  out  16  frames completed.

Function
REQ-009 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
REQ-010 IDLE, any req_valid high: SHALL pick requester g round-robin, search from last_grant+1 mod 4 upward with wrap.
REQ-011 Same IDLE cycle SHALL capture req_data[8g+7:8g] into core_tx_data, pulse req_ready[g], load grant_id=g and last_grant=g, go to ISSUE.
REQ-012 Requesters hold valid/data until ready; req_valid deasserting before grant SHALL be legal and SHALL simply drop out of arbitration.
REQ-013 ISSUE SHALL assert core_tx_req for exactly one clk, go to WAIT_BUSY; core_tx_req SHALL be 0 in all other states.
REQ-014 WAIT_BUSY SHALL go to WAIT_DONE on first cycle core_tx_busy=1.
REQ-015 WAIT_BUSY SHALL time out if core_tx_busy stays 0 for 4 consecutive clks: set err_timeout, go to IDLE, frame_cnt unchanged.
REQ-016 WAIT_DONE SHALL wait for core_tx_busy=0, then increment frame_cnt (mod 2^16, FFFF->0000).
REQ-017 Leaving WAIT_DONE SHALL go to GAP if gap_cfg!=0, else to IDLE.
REQ-018 GAP SHALL load gap_cfg on entry, later changes ignored until next entry; SHALL count clk16 strobes only.
REQ-019 GAP SHALL return to IDLE on the clk after the gap_cfg-th strobe; req_valid ignored in GAP.
REQ-020 core_tx_data and grant_id SHALL hold steady from capture until next grant.
REQ-021 err_clr SHALL clear err_timeout; err_clr and new timeout in same cycle SHALL leave err_timeout=1.
REQ-022 err_timeout SHALL NOT block scheduling.
REQ-023 Minimum latency from req_valid (IDLE) to core_tx_req SHALL be 1 clk: ready in cycle N, tx_req in cycle N+1.
REQ-024 At most one req_ready bit SHALL be high in any cycle, and only in IDLE.

Reset
REQ-025 rst SHALL immediately, regardless of state, force: state=IDLE, req_ready=0, core_tx_req=0, core_tx_data=0, grant_id=0, sched_busy=0, err_timeout=0, frame_cnt=0.
REQ-026 Same rst SHALL set last_grant=3 so requester 0 wins first; gap counter cleared.
REQ-027 After rst deasserts, first grant SHALL occur no earlier than the first clk edge with rst low.

Verification
REQ-028 rst release, req_valid=0001, req_data[7:0]=0x55 -> req_ready=0001 at cycle N, core_tx_req=1 at N+1, core_tx_data=0x55, grant_id=0.
REQ-029 req_valid=1111 held, stub core busy 20 clks, gap_cfg=0 -> grants 0,1,2,3,0 in order; frame_cnt=4 after fourth busy fall.
REQ-030 Core stub never asserts busy -> err_timeout=1 on 4th clk after tx_req, back to IDLE, frame_cnt=0; err_clr pulse -> err_timeout=0.
REQ-031 gap_cfg=3, clk16 every 16 clks -> no req_ready for exactly 3 clk16 strobes after busy falls; gap_cfg changed mid-GAP has no effect.
REQ-032 frame_cnt preloaded to 0xFFFF via 65535 frames or forced -> next frame gives 0x0000; rst in WAIT_DONE -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Requester and UART-core handshake bundle for the transmit scheduler.
// master = requesters plus core stub, slave = scheduler.
interface uart_tx_sched_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        core_tx_req;
  logic [7:0]  core_tx_data;
  logic        core_tx_busy;

  modport master (
    output req_valid, req_data, core_tx_busy,
    input  req_ready, core_tx_req, core_tx_data
  );

  modport slave (
    input  req_valid, req_data, core_tx_busy,
    output req_ready, core_tx_req, core_tx_data
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding bytes from four requesters into one UART core,
// with core no-start timeout, completed-frame counter and clk16-timed inter-frame gap.
module uart_tx_sched (
  input  logic              clk,
  input  logic              rst,
  uart_tx_sched_if.slave    bus,
  input  logic              clk16,
  input  logic [3:0]        gap_cfg,
  input  logic              err_clr,
  output logic [1:0]        grant_id,
  output logic              sched_busy,
  output logic              err_timeout,
  output logic [15:0]       frame_cnt
);
  localparam int NUM_REQ = 4;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  last_grant, pick, idx;
  logic        any_req, grant, timeout, frame_done;
  logic [1:0]  to_cnt;
  logic [3:0]  gap_cnt;

  // Scan farthest-to-nearest from last_grant so the nearest valid requester wins.
  always_comb begin
    any_req = 1'b0;
    pick    = last_grant;
    idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last_grant + 2'(k);
      if (bus.req_valid[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
  end

  assign grant = (state == IDLE) && any_req;

  always_comb begin
    state_nxt  = state;
    timeout    = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:      if (any_req) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.core_tx_busy) state_nxt = WAIT_DONE;
        else if (to_cnt == 2'd3) begin
          // fourth consecutive idle-core cycle: give up on this frame
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!bus.core_tx_busy) begin
          frame_done = 1'b1;
          state_nxt  = (gap_cfg != 4'd0) ? GAP : IDLE;
        end
      end
      GAP:       if (clk16 && gap_cnt == 4'd1) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // req_ready is combinational so the grant lands in the same cycle as req_valid;
  // gating with rst keeps it low while reset is held.
  assign bus.req_ready   = (grant && !rst) ? (4'b0001 << pick) : 4'b0000;
  assign bus.core_tx_req = (state == ISSUE);
  assign sched_busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      last_grant       <= 2'd3;
      bus.core_tx_data <= '0;
      grant_id         <= '0;
      err_timeout      <= 1'b0;
      frame_cnt        <= '0;
      to_cnt           <= '0;
      gap_cnt          <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        bus.core_tx_data <= bus.req_data[8*pick +: 8];
        grant_id         <= pick;
        last_grant       <= pick;
      end
      if (state == WAIT_BUSY && !bus.core_tx_busy) to_cnt <= to_cnt + 2'd1;
      else                                         to_cnt <= '0;
      if (timeout)      err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      // gap length is sampled once on entry; later gap_cfg edits wait for the next gap
      if (frame_done)                 gap_cnt <= gap_cfg;
      else if (state == GAP && clk16) gap_cnt <= gap_cnt - 4'd1;
    end
  end
endmodule
